store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write FIFO between core store path and data memory. Accepts SB/SH/SW from the
//  execute stage, lane-aligns data and builds byte mask, queues entries, drains one per
//  cycle to the data memory write port when that port is free. Supplies byte-wise
//  forwarding to loads so reads see buffered, not-yet-written stores.
// PARAMETERS
//  DEPTH  4  entries; power of two, >=2
//  AW     32 byte-address width
// PORTS
//  clk          in  1    clock
//  rst          in  1    synchronous, active-high reset
//  st_valid     in  1    store request
//  st_ready     out 1    buffer can accept (= ~full)
//  st_addr      in  AW   store byte address
//  st_data      in  32   raw rs2 value
//  st_func3     in  3    000 SB, 001 SH, 010 SW
//  st_err       out 1    1-cycle pulse: misaligned or illegal func3, store dropped
//  mem_free     in  1    data memory write port available this cycle (no load issuing)
//  mem_wr       out 1    drain write strobe
//  mem_addr     out AW   drain word address, bits[1:0]=0
//  mem_wdata    out 32   lane-positioned write data
//  mem_mask     out 4    byte enables
//  ld_addr      in  AW   current load byte address (comb lookup)
//  fwd_mask     out 4    bytes of word ld_addr[AW-1:2] supplied by buffer
//  fwd_data     out 32   forwarded bytes, lane-positioned; non-fwd bytes 0
//  empty        out 1    no buffered stores (fence/halt wait condition)
// BEHAVIOUR
//  - Reset: all entries invalid, wr/rd ptr=0, count=0; st_ready=1, empty=1, mem_wr=0,
//    st_err=0, fwd_mask=0. Reset mid-operation discards buffered stores.
//  - Enqueue on st_valid&st_ready: entry {addr[AW-1:2], lane data, mask}. SB: mask
//    1<<a[1:0], data byte replicated to lane. SH: a[0] must be 0, mask 0011/1100.
//    SW: a[1:0] must be 00, mask 1111. Violation or func3 not in {000,001,010}: no
//    enqueue, st_err=1 next cycle, handshake still completes.
//  - Drain: mem_wr = ~empty & mem_free, head entry driven combinationally on mem_*;
//    on mem_wr rd ptr advances at clk edge. Enqueue-to-first-drain latency >=1 cycle
//    (no same-cycle bypass of an incoming store to memory).
//  - Full: st_ready=0 even if draining that cycle (no enqueue on full).
//  - Simultaneous enqueue+drain: count unchanged; both pointers advance, wrap mod DEPTH.
//  - Empty: mem_wr=0 regardless of mem_free; empty=1.
//  - Forwarding (combinational): for each byte lane, youngest valid entry with matching
//    word addr and mask bit set supplies the byte; fwd_mask bit set. Store arriving in
//    the same cycle is NOT visible. Entry being drained this cycle still forwards.
//  - Count widths: ptrs log2(DEPTH) bits, count log2(DEPTH)+1 bits.
// STRUCTURE
//  - lsu_pkg: func3 constants F3_B/F3_H/F3_W, typedef sb_entry_t {word addr, data,
//    mask}, function is_misaligned(func3, a[1:0]).
//  - Sub-module store_lane_gen: comb func3/addr/rs2 -> lane data, mask, err.
//  - FIFO storage and forwarding priority loop in this module.
// TESTING
//  - SW 0xDEADBEEF @0x10, mem_free=1 -> next cycle mem_wr=1 addr 0x10 data DEADBEEF
//    mask 1111; then empty=1.
//  - SB 0xAB @0x13 -> mem_wdata[31:24]=AB mask 1000; SH 0x1234 @0x16 -> wdata
//    [31:16]=1234 mask 1100.
//  - mem_free=0, 4 stores -> st_ready=0 after 4th; 5th held; mem_free=1 -> drains in
//    order, one per cycle, st_ready=1 after first drain.
//  - Buffered SW 0x11223344 @0x20 then SB 0x55 @0x21, ld_addr 0x20 -> fwd_mask 1111,
//    fwd_data 0x11225544.
//  - SH @0x03 and func3=011 -> st_err pulse, no entry, empty stays 1.
//  - Full buffer, rst=1 one cycle -> empty=1, mem_wr=0, st_ready=1, fwd_mask=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: store func3 encodings, buffered store entry,
// and the store alignment rule.
package lsu_pkg;

  localparam int SB_AW = 32;

  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;

  typedef struct packed {
    logic [SB_AW-3:0] waddr;
    logic [31:0]      data;
    logic [3:0]       mask;
  } sb_entry_t;

  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] a);
    case (func3)
      F3_H:    is_misaligned = a[0];
      F3_W:    is_misaligned = |a;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Turns a raw rs2 value plus func3/byte offset into lane-positioned write data and
// byte enables; flags misaligned or unsupported store widths.
module store_lane_gen
  import lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] data_o,
  output logic [3:0]  mask_o,
  output logic        err_o
);

  always_comb begin
    data_o = '0;
    mask_o = '0;
    err_o  = is_misaligned(func3_i, a_i);
    case (func3_i)
      F3_B: begin
        data_o = {4{rs2_i[7:0]}};
        mask_o = 4'b0001 << a_i;
      end
      F3_H: begin
        data_o = {2{rs2_i[15:0]}};
        mask_o = a_i[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        data_o = rs2_i;
        mask_o = 4'b1111;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store FIFO: queues lane-aligned stores, drains one per free memory
// cycle, and forwards buffered bytes to the current load address.
module store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid_i,
  output logic          st_ready_o,
  input  logic [AW-1:0] st_addr_i,
  input  logic [31:0]   st_data_i,
  input  logic [2:0]    st_func3_i,
  output logic          st_err_o,
  input  logic          mem_free_i,
  output logic          mem_wr_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_mask_o,
  input  logic [AW-1:0] ld_addr_i,
  output logic [3:0]    fwd_mask_o,
  output logic [31:0]   fwd_data_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          err_q;

  logic [31:0] lane_data;
  logic [3:0]  lane_mask;
  logic        lane_err;
  logic        accept, enq, deq;

  store_lane_gen u_lane (
    .func3_i (st_func3_i),
    .a_i     (st_addr_i[1:0]),
    .rs2_i   (st_data_i),
    .data_o  (lane_data),
    .mask_o  (lane_mask),
    .err_o   (lane_err)
  );

  assign st_ready_o = (count_q != (PW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign st_err_o   = err_q;
  assign accept     = st_valid_i & st_ready_o;
  assign enq        = accept & ~lane_err;
  assign deq        = mem_wr_o;

  // Head is presented straight from storage, so a store enqueued this cycle drains next cycle at the earliest.
  assign mem_wr_o    = ~empty_o & mem_free_i;
  assign mem_addr_o  = {ent_q[rd_ptr_q].waddr, 2'b00};
  assign mem_wdata_o = ent_q[rd_ptr_q].data;
  assign mem_mask_o  = ent_q[rd_ptr_q].mask;

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= accept & lane_err;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) ent_q[wr_ptr_q] <= '{waddr: st_addr_i[AW-1:2], data: lane_data, mask: lane_mask};
  end

  // Walk oldest to youngest so later matches overwrite earlier ones per byte.
  logic [PW-1:0] fidx;
  always_comb begin
    fwd_mask_o = '0;
    fwd_data_o = '0;
    fidx       = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = rd_ptr_q + PW'(k);
      if (count_q > (PW+1)'(k) && ent_q[fidx].waddr == ld_addr_i[AW-1:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_q[fidx].mask[b]) begin
            fwd_mask_o[b]       = 1'b1;
            fwd_data_o[8*b +: 8] = ent_q[fidx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, lane alignment, drain order, full
// back-pressure, forwarding priority, error pulses and mid-run reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready, st_err;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_func3;
  logic        mem_free, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] ld_addr;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  logic        empty;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr),
    .st_data_i(st_data), .st_func3_i(st_func3), .st_err_o(st_err),
    .mem_free_i(mem_free), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_mask_o(mem_mask),
    .ld_addr_i(ld_addr), .fwd_mask_o(fwd_mask), .fwd_data_o(fwd_data),
    .empty_o(empty)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid = 1'b1; st_addr = a; st_data = d; st_func3 = f;
  endtask

  task automatic test_reset;
    rst = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_func3 = 0;
    mem_free = 1'b1; ld_addr = 0;
    tick; tick;
    @(negedge clk);
    nvec++;
    if ({st_ready, empty, mem_wr, st_err, fwd_mask} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'h0}) begin
      nerr++;
      $display("FAIL reset: rdy/empty/wr/err/fmask got %b%b%b%b %h want 1100 0", st_ready, empty, mem_wr, st_err, fwd_mask);
    end
    tick;
    rst = 1'b0;
  endtask

  task automatic test_sw;
    mem_free = 1'b1;
    drive(32'h10, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    nvec++;
    if (mem_wr !== 1'b0) begin nerr++; $display("FAIL sw_nobypass: mem_wr got %b want 0", mem_wr); end
    tick;
    st_valid = 0;
    @(negedge clk);
    nvec++;
    if ({mem_wr, mem_addr, mem_wdata, mem_mask} !== {1'b1, 32'h10, 32'hDEADBEEF, 4'hF}) begin
      nerr++;
      $display("FAIL sw_drain: wr=%b addr=%h data=%h mask=%h want 1 10 deadbeef f", mem_wr, mem_addr, mem_wdata, mem_mask);
    end
    tick;
    @(negedge clk);
    nvec++;
    if ({empty, mem_wr} !== 2'b10) begin nerr++; $display("FAIL sw_empty: empty=%b wr=%b want 1 0", empty, mem_wr); end
    tick;
  endtask

  task automatic test_lanes;
    mem_free = 1'b1;
    drive(32'h13, 32'h000000AB, 3'b000);
    tick;
    st_valid = 0;
    @(negedge clk);
    nvec++;
    if ({mem_wr, mem_addr, mem_wdata[31:24], mem_mask} !== {1'b1, 32'h10, 8'hAB, 4'b1000}) begin
      nerr++;
      $display("FAIL sb_lane: wr=%b addr=%h byte3=%h mask=%b want 1 10 ab 1000", mem_wr, mem_addr, mem_wdata[31:24], mem_mask);
    end
    tick;
    drive(32'h16, 32'h00001234, 3'b001);
    tick;
    st_valid = 0;
    @(negedge clk);
    nvec++;
    if ({mem_wr, mem_addr, mem_wdata[31:16], mem_mask} !== {1'b1, 32'h14, 16'h1234, 4'b1100}) begin
      nerr++;
      $display("FAIL sh_lane: wr=%b addr=%h hi=%h mask=%b want 1 14 1234 1100", mem_wr, mem_addr, mem_wdata[31:16], mem_mask);
    end
    tick;
  endtask

  task automatic test_full;
    mem_free = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h40 + 32'(4*i), 32'hA0 + 32'(i), 3'b010);
      tick;
    end
    drive(32'h50, 32'hA4, 3'b010);
    @(negedge clk);
    nvec++;
    if ({st_ready, mem_wr} !== 2'b00) begin nerr++; $display("FAIL full_hold: rdy=%b wr=%b want 0 0", st_ready, mem_wr); end
    tick;
    mem_free = 1'b1;
    @(negedge clk);
    nvec++;
    if ({st_ready, mem_wr, mem_addr, mem_wdata} !== {1'b0, 1'b1, 32'h40, 32'hA0}) begin
      nerr++;
      $display("FAIL full_drain0: rdy=%b wr=%b addr=%h data=%h want 0 1 40 a0", st_ready, mem_wr, mem_addr, mem_wdata);
    end
    tick;
    @(negedge clk);
    nvec++;
    if ({st_ready, mem_addr, mem_wdata} !== {1'b1, 32'h44, 32'hA1}) begin
      nerr++;
      $display("FAIL full_drain1: rdy=%b addr=%h data=%h want 1 44 a1", st_ready, mem_addr, mem_wdata);
    end
    tick;
    st_valid = 0;
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      nvec++;
      if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h40 + 32'(4*i), 32'hA0 + 32'(i)}) begin
        nerr++;
        $display("FAIL full_order%0d: wr=%b addr=%h data=%h want 1 %h %h", i, mem_wr, mem_addr, mem_wdata, 32'h40 + 32'(4*i), 32'hA0 + 32'(i));
      end
      tick;
    end
    @(negedge clk);
    nvec++;
    if ({empty, mem_wr} !== 2'b10) begin nerr++; $display("FAIL full_empty: empty=%b wr=%b want 1 0", empty, mem_wr); end
    tick;
  endtask

  task automatic test_forward;
    mem_free = 1'b0;
    ld_addr  = 32'h20;
    drive(32'h20, 32'h11223344, 3'b010);
    tick;
    drive(32'h21, 32'h00000055, 3'b000);
    tick;
    drive(32'h22, 32'h00000066, 3'b000);
    @(negedge clk);
    nvec++;
    if ({fwd_mask, fwd_data} !== {4'hF, 32'h11225544}) begin
      nerr++;
      $display("FAIL fwd_young: mask=%h data=%h want f 11225544", fwd_mask, fwd_data);
    end
    tick;
    st_valid = 0;
    @(negedge clk);
    nvec++;
    if ({fwd_mask, fwd_data} !== {4'hF, 32'h11665544}) begin
      nerr++;
      $display("FAIL fwd_after: mask=%h data=%h want f 11665544", fwd_mask, fwd_data);
    end
    ld_addr = 32'h24;
    #1;
    nvec++;
    if ({fwd_mask, fwd_data} !== {4'h0, 32'h0}) begin
      nerr++;
      $display("FAIL fwd_miss: mask=%h data=%h want 0 0", fwd_mask, fwd_data);
    end
    ld_addr  = 32'h20;
    mem_free = 1'b1;
    #1;
    nvec++;
    if ({mem_wr, fwd_mask, fwd_data} !== {1'b1, 4'hF, 32'h11665544}) begin
      nerr++;
      $display("FAIL fwd_draining: wr=%b mask=%h data=%h want 1 f 11665544", mem_wr, fwd_mask, fwd_data);
    end
    tick; tick; tick;
    @(negedge clk);
    nvec++;
    if ({empty, fwd_mask} !== {1'b1, 4'h0}) begin
      nerr++;
      $display("FAIL fwd_drained: empty=%b mask=%h want 1 0", empty, fwd_mask);
    end
    tick;
  endtask

  task automatic test_err;
    mem_free = 1'b1;
    drive(32'h03, 32'h00001234, 3'b001);
    @(negedge clk);
    nvec++;
    if ({st_ready, st_err} !== 2'b10) begin nerr++; $display("FAIL err_pre: rdy=%b err=%b want 1 0", st_ready, st_err); end
    tick;
    drive(32'h00, 32'h0, 3'b011);
    @(negedge clk);
    nvec++;
    if ({st_err, empty, mem_wr} !== 3'b110) begin
      nerr++;
      $display("FAIL err_misalign: err=%b empty=%b wr=%b want 1 1 0", st_err, empty, mem_wr);
    end
    tick;
    st_valid = 0;
    @(negedge clk);
    nvec++;
    if ({st_err, empty, mem_wr} !== 3'b110) begin
      nerr++;
      $display("FAIL err_func3: err=%b empty=%b wr=%b want 1 1 0", st_err, empty, mem_wr);
    end
    tick;
    @(negedge clk);
    nvec++;
    if (st_err !== 1'b0) begin nerr++; $display("FAIL err_pulse: err=%b want 0", st_err); end
    tick;
  endtask

  task automatic test_reset_mid;
    mem_free = 1'b0;
    ld_addr  = 32'h60;
    for (int i = 0; i < 4; i++) begin
      drive(32'h60 + 32'(4*i), 32'hC0 + 32'(i), 3'b010);
      tick;
    end
    st_valid = 0;
    @(negedge clk);
    nvec++;
    if ({st_ready, fwd_mask} !== {1'b0, 4'hF}) begin
      nerr++;
      $display("FAIL rst_prefull: rdy=%b fmask=%h want 0 f", st_ready, fwd_mask);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mem_free = 1'b1;
    @(negedge clk);
    nvec++;
    if ({empty, mem_wr, st_ready, fwd_mask} !== {1'b1, 1'b0, 1'b1, 4'h0}) begin
      nerr++;
      $display("FAIL rst_mid: empty=%b wr=%b rdy=%b fmask=%h want 1 0 1 0", empty, mem_wr, st_ready, fwd_mask);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_sw;
    test_lanes;
    test_full;
    test_forward;
    test_err;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

endmodule
